interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_pkg.sv | 40 ++++
 rtl/irq_edge_detect.sv | 39 +++
 rtl/interrupt_controller.sv | 104 ++++++++++
 3 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller slice.
//   NUM_IRQ / IRQ_ID_W        : request-line count and index width
//   DEFAULT_ISR_BASE/STRIDE   : default vector table placement
//   irq_state_t               : controller FSM state encoding
//   lowest_set()              : fixed-priority (lowest index wins) encoder
//   vector_addr()             : vector address arithmetic, wraps modulo 2^32
package interrupt_controller_pkg;

  localparam int unsigned NUM_IRQ  = 8;
  localparam int unsigned IRQ_ID_W = 3;

  localparam logic [31:0] DEFAULT_ISR_BASE   = 32'h0000_0100;
  localparam int unsigned DEFAULT_ISR_STRIDE = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_VECTOR  = 2'd1,
    ST_SERVICE = 2'd2,
    ST_RETURN  = 2'd3
  } irq_state_t;

  function automatic logic [IRQ_ID_W-1:0] lowest_set(input logic [NUM_IRQ-1:0] v);
    logic found;
    lowest_set = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (v[i] && !found) begin
        lowest_set = IRQ_ID_W'(i);
        found      = 1'b1;
      end
    end
  endfunction

  function automatic logic [31:0] vector_addr(input logic [31:0]         base,
                                              input logic [31:0]         stride,
                                              input logic [IRQ_ID_W-1:0] id);
    vector_addr = base + (32'(id) * stride);
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector with sticky pending bits for the interrupt lines.
//   clk, rst_n : clock, asynchronous active-low reset
//   irq        : request lines (synchronous to clk)
//   clr        : one-hot clear of a pending bit taken into service
//   pending    : latched rising edges awaiting service
module irq_edge_detect
  import interrupt_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] clr,
  output logic [NUM_IRQ-1:0] pending
);

  logic [NUM_IRQ-1:0] irq_q;
  logic               armed;
  logic [NUM_IRQ-1:0] rise;

  // armed stays low for the first cycle after reset so a line already high
  // at release is absorbed into irq_q instead of looking like a new edge.
  always_comb begin
    rise = irq & ~irq_q & {NUM_IRQ{armed}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q   <= '0;
      armed   <= 1'b0;
      pending <= '0;
    end else begin
      irq_q   <= irq;
      armed   <= 1'b1;
      // a fresh edge on a line being cleared keeps it pending
      pending <= (pending & ~clr) | rise;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Single-level vectored interrupt controller.
//   clk, rst_n        : clock, asynchronous active-low reset
//   irq, irq_mask     : request lines (edge sensitive) and per-line enables
//   global_en         : master enable, sampled only when idle
//   pc, Stall, mret   : fetch pc, pipeline stall, return-from-ISR pulse
//   addressSrc        : redirect request, consumed in a cycle with Stall=0
//   isrAddress        : redirect target (vector or epc), 0 when no redirect
//   epc               : saved return pc
//   in_isr, active_id : servicing flag and index of the serviced line
//   irq_ack           : one-hot acknowledge, one cycle, at service entry
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter logic [31:0] ISR_BASE   = DEFAULT_ISR_BASE,
  parameter int unsigned ISR_STRIDE = DEFAULT_ISR_STRIDE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic [NUM_IRQ-1:0]  irq_mask,
  input  logic                global_en,
  input  logic [31:0]         pc,
  input  logic                Stall,
  input  logic                mret,
  output logic                addressSrc,
  output logic [31:0]         isrAddress,
  output logic [31:0]         epc,
  output logic                in_isr,
  output logic [IRQ_ID_W-1:0] active_id,
  output logic [NUM_IRQ-1:0]  irq_ack
);

  irq_state_t          state, state_next;
  logic [NUM_IRQ-1:0]  pending;
  logic [NUM_IRQ-1:0]  cand;
  logic [IRQ_ID_W-1:0] win_id;
  logic                load_id;
  logic                load_epc;

  irq_edge_detect u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq     (irq),
    .clr     (irq_ack),
    .pending (pending)
  );

  always_comb begin
    cand   = pending & irq_mask;
    win_id = lowest_set(cand);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      active_id <= '0;
      epc       <= '0;
    end else begin
      state <= state_next;
      if (load_id)  active_id <= win_id;
      if (load_epc) epc       <= pc;
    end
  end

  always_comb begin
    state_next = state;
    addressSrc = 1'b0;
    isrAddress = '0;
    irq_ack    = '0;
    load_id    = 1'b0;
    load_epc   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (global_en && (cand != '0)) begin
          irq_ack    = {{(NUM_IRQ-1){1'b0}}, 1'b1} << win_id;
          load_id    = 1'b1;
          state_next = ST_VECTOR;
        end
      end
      ST_VECTOR: begin
        addressSrc = 1'b1;
        isrAddress = vector_addr(ISR_BASE, 32'(ISR_STRIDE), active_id);
        if (!Stall) begin
          load_epc   = 1'b1;
          state_next = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (mret) state_next = ST_RETURN;
      end
      ST_RETURN: begin
        addressSrc = 1'b1;
        isrAddress = epc;
        if (!Stall) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_isr = (state != ST_IDLE);
  end

endmodule
